// File: rtl/parity_stream_pkg.sv
// Shared types and constants for the parity stream source/checker.
package parity_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RECV,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DATA = 2'b01;
    localparam logic [1:0] ERR_LAST = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] RESP_ODD   = 8'hFF;
    localparam logic [7:0] RESP_EVEN0 = 8'hAB;
    localparam logic [7:0] RESP_EVEN1 = 8'h12;
    localparam logic [7:0] RESP_EVEN2 = 8'hDE;

    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // The first error recorded in a transaction is the one reported.
    function automatic logic [1:0] keep_first_err(input logic [1:0] cur, input logic [1:0] nw);
        return (cur == ERR_OK) ? nw : cur;
    endfunction

    // Reply byte the responder owes at position idx for the given packet parity.
    function automatic logic [7:0] expected_reply(input logic odd, input logic [1:0] idx);
        logic [7:0] b;
        if (odd) begin
            b = RESP_ODD;
        end else begin
            case (idx)
                2'd0:    b = RESP_EVEN0;
                2'd1:    b = RESP_EVEN1;
                default: b = RESP_EVEN2;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/parity_stream_source_checker_if.sv
// Byte-wide AXI-Stream link used for both the request and the reply direction.
interface parity_stream_source_checker_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/parity_lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left with feedback into bit 0 when adv is high.
module parity_lfsr8
    import parity_stream_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [7:0] q
);

    // Only reset reseeds; the sequence otherwise runs on across packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= SEED;
        else if (adv) q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/parity_stream_source_checker.sv
// Sends a PKT_LEN-byte LFSR packet, then checks the responder's parity reply.
module parity_stream_source_checker
    import parity_stream_pkg::*;
#(
    parameter int         PKT_LEN   = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         TIMEOUT   = 255
) (
    input  logic                                  a_clk,
    input  logic                                  axis_aresetn,
    input  logic                                  start,
    parity_stream_source_checker_if.master        axis_m,
    parity_stream_source_checker_if.slave         axis_s,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [1:0]                            err_code,
    output logic [15:0]                           pkt_count,
    output logic [15:0]                           fail_count
);

    localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  byte_cnt, lfsr_q, exp_byte;
    logic        par_acc;
    logic [1:0]  exp_idx, final_idx, err_r, err_nxt;
    logic [15:0] tmo_cnt;
    logic        m_valid, s_ready, m_fire, s_fire, last_beat, tmo_hit, finish;

    assign last_beat = (byte_cnt == LAST_IDX);
    assign m_fire    = (state == SEND) && axis_m.tready;
    assign s_fire    = ((state == RECV) || (state == DRAIN)) && axis_s.tvalid;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign final_idx = par_acc ? 2'd0 : 2'd2;
    assign exp_byte  = expected_reply(par_acc, exp_idx);
    assign finish    = (state_nxt == DONE);

    // tdata is the live LFSR value, so it only moves when a beat is accepted.
    assign axis_m.tvalid = m_valid;
    assign axis_m.tdata  = m_valid ? lfsr_q : 8'h00;
    assign axis_m.tlast  = m_valid && last_beat;
    assign axis_s.tready = s_ready;

    parity_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (a_clk),
        .rst_n (axis_aresetn),
        .adv   (m_fire),
        .q     (lfsr_q)
    );

    // State register.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) state <= IDLE;
        else               state <= state_nxt;
    end

    // Next state, error classification and handshake outputs.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_r;
        m_valid   = 1'b0;
        s_ready   = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: begin
                m_valid = 1'b1;
                if (m_fire && last_beat) state_nxt = RECV;
            end
            RECV: begin
                s_ready = 1'b1;
                if (s_fire) begin
                    if (axis_s.tdata != exp_byte) err_nxt = keep_first_err(err_nxt, ERR_DATA);
                    if (axis_s.tlast) begin
                        if (exp_idx != final_idx) err_nxt = keep_first_err(err_nxt, ERR_LAST);
                        state_nxt = DONE;
                    end else if (exp_idx == final_idx) begin
                        // Reply overran; swallow the rest up to its tlast.
                        err_nxt   = keep_first_err(err_nxt, ERR_LAST);
                        state_nxt = DRAIN;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = keep_first_err(err_nxt, ERR_TMO);
                    state_nxt = DONE;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_fire) begin
                    if (axis_s.tlast) state_nxt = DONE;
                end else if (tmo_hit) begin
                    err_nxt   = keep_first_err(err_nxt, ERR_TMO);
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packet counters, parity, reply tracking and the held result.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            byte_cnt   <= 8'h00;
            par_acc    <= 1'b0;
            exp_idx    <= 2'd0;
            tmo_cnt    <= 16'h0000;
            err_r      <= ERR_OK;
            err_code   <= ERR_OK;
            pass       <= 1'b0;
            pkt_count  <= 16'h0000;
            fail_count <= 16'h0000;
        end else begin
            err_r <= err_nxt;
            if ((state == IDLE) && start) begin
                byte_cnt <= 8'h00;
                par_acc  <= 1'b0;
                err_r    <= ERR_OK;
                err_code <= ERR_OK;
                pass     <= 1'b0;
            end
            if (m_fire) begin
                byte_cnt <= byte_cnt + 8'd1;
                par_acc  <= par_acc ^ (^lfsr_q);
            end
            if (m_fire && last_beat) begin
                exp_idx <= 2'd0;
                tmo_cnt <= 16'h0000;
            end else if (s_fire) begin
                exp_idx <= exp_idx + 2'd1;
                tmo_cnt <= 16'h0000;
            end else if (s_ready) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            // Result is published on entry to DONE so it is valid alongside done.
            if (finish) begin
                err_code  <= err_nxt;
                pass      <= (err_nxt == ERR_OK);
                pkt_count <= pkt_count + 16'd1;
                if (err_nxt != ERR_OK) fail_count <= fail_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/parity_stream_source_checker.md
Name: parity_stream_source_checker

Overview:
- AXI-Stream packet source and response checker; the counterpart of the parity responder.
- On each start it sends one PKT_LEN-byte packet of LFSR data on its master port and accumulates the XOR parity of all bytes sent.
- It then accepts the responder's reply on its slave port and checks it: odd parity expects a 1-beat reply 8'hFF; even parity expects the 3-beat reply 8'hAB, 8'h12, 8'hDE.
- Used in bring-up and regression of the parity responder.

Parameters:
- PKT_LEN, 8, bytes per request packet; legal range 1..255.
- LFSR_SEED, 8'hA5, LFSR value after reset; must be nonzero.
- TIMEOUT, 255, maximum idle cycles waiting for a reply beat; legal range 1..65535.

Ports:
- a_clk  in  1  clock; all logic on the rising edge.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a transaction, accepted only in IDLE.
- axis_m_tvalid  out  1  request beat valid.
- axis_m_tdata  out  8  request byte.
- axis_m_tready  in  1  responder accepts the beat.
- axis_m_tlast  out  1  last request beat.
- axis_s_tvalid  in  1  reply beat valid.
- axis_s_tdata  in  8  reply byte.
- axis_s_tready  out  1  checker accepts the reply beat.
- axis_s_tlast  in  1  last reply beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transaction finishes.
- pass  out  1  result of the last transaction; valid while done is high and held until the next start.
- err_code  out  2  00 ok, 01 data mismatch, 10 tlast misplaced, 11 timeout; held like pass.
- pkt_count  out  16  completed transactions; wraps at 16'hFFFF.
- fail_count  out  16  failed transactions; wraps.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: tvalid, tlast, tdata, s_tready, busy, done, pass, err_code, counters.
  - LFSR = LFSR_SEED; parity accumulator = 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0. Advances only on an accepted request beat (m_tvalid & m_tready). The sequence persists across transactions; only reset reseeds it.
- IDLE:
  - start=1: byte counter = 0, parity = 0, load tdata = LFSR, go to SEND.
  - axis_m_tvalid rises the cycle after start (1-cycle latency).
- SEND:
  - tvalid held high and tdata/tlast held stable until the beat is accepted (AXIS rule; no retraction).
  - tlast = 1 when byte counter == PKT_LEN-1.
  - On acceptance: parity ^= ^tdata; counter++; present the next LFSR byte the following cycle with no bubble.
  - Acceptance with tlast=1: tvalid drops, latch expected parity (including the last byte), go to RECV.
- RECV:
  - axis_s_tready = 1; expected index = 0; timeout counter = 0.
  - Each accepted reply beat: compare with the expected byte (odd: FF; even: AB, 12, DE by index).
    - Mismatch: record 01 (first error wins).
    - tlast=1 before the final expected beat: record 10 and finish.
    - tlast=0 on the final expected beat: record 10 and go to DRAIN.
  - The timeout counter increments each cycle with no accepted beat and clears on each beat. Reaching TIMEOUT: record 11 and finish.
- DRAIN: s_tready = 1; discard beats until a beat with tlast=1 is accepted, then finish. A timeout here also finishes with 11 if no error was already recorded.
- Finish (DONE state, 1 cycle):
  - s_tready = 0; done = 1; pass = (err_code == 00).
  - pkt_count++; fail_count++ on failure.
  - Return to IDLE.
- start while busy: ignored.
- Reply beats arriving during SEND or IDLE: not accepted (s_tready = 0).
- Reset mid-operation: immediate return to the reset state; the partial packet is abandoned without tlast.

Decomposition:
- Shared package parity_stream_pkg holds:
  - state enum (IDLE, SEND, RECV, DRAIN, DONE)
  - err_code constants
  - reply constants RESP_ODD=8'hFF, RESP_EVEN0=8'hAB, RESP_EVEN1=8'h12, RESP_EVEN2=8'hDE
  - LFSR tap mask
- One sub-module, parity_lfsr8 (seed parameter, advance enable, 8-bit output), is natural and reusable by other stream sources.

Test Plan:
- PKT_LEN=8, seed A5, m_tready held 1, responder replies AB,12,DE with tlast on DE, parity of the 8 sent bytes even -> done=1, pass=1, err 00, pkt_count=1.
- PKT_LEN=1, sent byte 8'h01 (odd) and reply FF with tlast -> pass=1. Same stimulus with reply AB,12,DE -> err 01, then 10 on the first beat, since first error wins: err stays 01, fail_count=1.
- m_tready toggling 1,0,0,1 during SEND -> tdata/tlast stable while stalled, no byte skipped or repeated, exactly PKT_LEN beats, tlast only on the last.
- Even case, reply AB,12 with tlast on 12 -> err 10, done next cycle. Reply AB,12,DE,00 with tlast on 00 -> err 10 after DRAIN consumes 00.
- No reply, TIMEOUT=16 -> done exactly 16 cycles after entering RECV, err 11, fail_count incremented.
- axis_aresetn pulled low mid-SEND -> outputs 0 asynchronously; after release, start resends beginning at byte A5.
